// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: an accepted code is driven one-hot for HOLD cycles,
// followed by a single quiet gap cycle before the next code can be taken.
module decoder_3to8_seq #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic       in_none,
    input  logic [2:0] i,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       y_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic       none_q, none_d;
    logic [7:0] y_q, y_d;
    logic       y_valid_q, y_valid_d;
    logic       y_last_q, y_last_d;

    assign in_ready = (state_q == IDLE) && en && !rst;
    assign busy     = (state_q != IDLE);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign y_last   = y_last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        none_d  = none_q;

        case (state_q)
            IDLE: begin
                // i and in_none are only looked at on an accepting edge
                if (in_valid && in_ready) begin
                    state_d = DRIVE;
                    cnt_d   = HOLD_M1;
                    code_d  = i;
                    none_d  = in_none;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are registered: derive them from the state being entered
        y_valid_d = (state_d == DRIVE);
        y_last_d  = (state_d == DRIVE) && (cnt_d == 4'd0);
        y_d       = (y_valid_d && !none_d) ? (8'd1 << code_d) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            code_q    <= 3'd0;
            none_q    <= 1'b0;
            y_q       <= 8'd0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            none_q    <= none_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: two instances (HOLD=4 and HOLD=1) share stimulus and are
// compared every cycle against a timestamp-based model of the drive/gap schedule.
module tb_decoder_3to8_seq;

    localparam int H0 = 4;
    localparam int H1 = 1;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, in_none;
    logic [2:0] i;
    logic       rdy_w [2];
    logic [7:0] y_w   [2];
    logic       yv_w  [2];
    logic       yl_w  [2];
    logic       busy_w[2];

    decoder_3to8_seq #(.HOLD(H0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_none(in_none), .i(i),
        .in_ready(rdy_w[0]), .y(y_w[0]), .y_valid(yv_w[0]), .y_last(yl_w[0]), .busy(busy_w[0])
    );

    decoder_3to8_seq #(.HOLD(H1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_none(in_none), .i(i),
        .in_ready(rdy_w[1]), .y(y_w[1]), .y_valid(yv_w[1]), .y_last(yl_w[1]), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    // Model: each instance remembers the cycle its code was accepted; the elapsed
    // cycle count alone says whether it is driving, in the gap, or idle.
    int hold[2] = '{H0, H1};
    bit m_active[2];
    int m_acc[2];
    int m_code[2];
    bit m_none[2];
    bit acc_flag[2];
    int acc_at[2];
    int cyc = 0;
    int vecs = 0;
    int fails = 0;

    typedef struct {
        logic       rst, en, v, none;
        logic [2:0] code;
        logic [7:0] y;
        logic       yv, yl, busy, rdy;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int phase(input int n); // 0 idle, 1 drive, 2 gap
        int e;
        if (!m_active[n]) return 0;
        e = cyc - m_acc[n];
        if (e >= 0 && e < hold[n]) return 1;
        if (e == hold[n]) return 2;
        return 0;
    endfunction

    task automatic tick();
        int ph[2];
        bit rdy[2];
        int ey;
        #1;
        for (int n = 0; n < 2; n++) begin
            ph[n]  = phase(n);
            ey     = (ph[n] == 1 && !m_none[n]) ? (1 << m_code[n]) : 0;
            rdy[n] = (ph[n] == 0) && en && !rst;
            chk($sformatf("model_y[%0d]", n), y_w[n], ey);
            chk($sformatf("model_y_valid[%0d]", n), yv_w[n], (ph[n] == 1) ? 1 : 0);
            chk($sformatf("model_y_last[%0d]", n), yl_w[n],
                (ph[n] == 1 && (cyc - m_acc[n]) == hold[n] - 1) ? 1 : 0);
            chk($sformatf("model_busy[%0d]", n), busy_w[n], (ph[n] != 0) ? 1 : 0);
            chk($sformatf("model_in_ready[%0d]", n), rdy_w[n], rdy[n] ? 1 : 0);
            acc_flag[n] = 1'b0;
        end
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                m_active[n] = 1'b0;
            end else if (rdy[n] && in_valid) begin
                m_active[n] = 1'b1;
                m_acc[n]    = cyc + 1;
                m_code[n]   = int'(i);
                m_none[n]   = in_none;
                acc_flag[n] = 1'b1;
                acc_at[n]   = cyc + 1;
            end else if (ph[n] != 0 && !en) begin
                m_active[n] = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic go_idle();
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_none = 1'b0;
        repeat (H0 + 3) tick();
    endtask

    initial begin
        int prev;
        int n;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_none = 1'b0; i = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        //            rst   en    v     none  code  y      yv    yl    busy  rdy
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

        foreach (tbl[k]) begin
            rst = tbl[k].rst; en = tbl[k].en; in_valid = tbl[k].v;
            in_none = tbl[k].none; i = tbl[k].code;
            #1;
            chk($sformatf("tbl%0d_y", k), y_w[0], tbl[k].y);
            chk($sformatf("tbl%0d_y_valid", k), yv_w[0], tbl[k].yv);
            chk($sformatf("tbl%0d_y_last", k), yl_w[0], tbl[k].yl);
            chk($sformatf("tbl%0d_busy", k), busy_w[0], tbl[k].busy);
            chk($sformatf("tbl%0d_in_ready", k), rdy_w[0], tbl[k].rdy);
            tick();
        end

        // in_none followed by a real code 0
        go_idle();
        in_valid = 1'b1; in_none = 1'b0; i = 3'd0;
        tick();
        in_valid = 1'b0;
        chk("zero_code_y", y_w[0], 8'h01);
        chk("zero_code_y_valid", yv_w[0], 1);

        // Sweep 7..0 with in_valid held; acceptances exactly HOLD+2 apart
        go_idle();
        prev = -1;
        for (int k = 7; k >= 0; k--) begin
            i = 3'(k); in_valid = 1'b1;
            n = 0;
            acc_flag[0] = 1'b0;
            while (!acc_flag[0] && n < 30) begin
                tick();
                n++;
            end
            chk($sformatf("sweep%0d_accepted", k), acc_flag[0], 1);
            if (prev >= 0) chk($sformatf("sweep%0d_spacing", k), acc_at[0] - prev, H0 + 2);
            prev = acc_at[0];
            chk($sformatf("sweep%0d_y", k), y_w[0], 8'h80 >> (7 - k));
        end

        // Abort with en=0 on the 2nd drive cycle
        go_idle();
        in_valid = 1'b1; i = 3'd5;
        tick();
        in_valid = 1'b0;
        tick();
        en = 1'b0; in_valid = 1'b1;
        tick();
        chk("abort_y", y_w[0], 8'h00);
        chk("abort_y_valid", yv_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        repeat (3) begin
            tick();
            chk("abort_in_ready", rdy_w[0], 0);
        end
        en = 1'b1;
        #1 chk("abort_reenable_ready", rdy_w[0], 1);

        // Reset on the 3rd drive cycle, with in_valid held through reset
        go_idle();
        in_valid = 1'b1; i = 3'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1; in_valid = 1'b1;
        tick();
        chk("rst_y", y_w[0], 8'h00);
        chk("rst_y_valid", yv_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_in_ready", rdy_w[0], 0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_no_accept_busy", busy_w[0], 0);

        // HOLD=1 instance: single drive cycle, one gap, then ready
        go_idle();
        in_valid = 1'b1; in_none = 1'b0; i = 3'd2;
        tick();
        in_valid = 1'b0;
        chk("h1_y", y_w[1], 8'h04);
        chk("h1_y_valid", yv_w[1], 1);
        chk("h1_y_last", yl_w[1], 1);
        tick();
        chk("h1_gap_y_valid", yv_w[1], 0);
        chk("h1_gap_busy", busy_w[1], 1);
        tick();
        chk("h1_ready", rdy_w[1], 1);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom % 50) == 0;
            en       = ($urandom % 12) != 0;
            in_valid = $urandom % 2;
            in_none  = ($urandom % 5) == 0;
            i        = 3'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_seq.md
DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

Interface
REQ-001 SHALL have parameter: HOLD, default 4, number of cycles a decoded one-hot output is driven (legal 1..15).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; 0 aborts activity and blocks acceptance.
- in_valid  input  1  a code is presented this cycle.
- in_none  input  1  presented code means "no line active" (encoder all-zero case).
- i  input  3  binary code to decode.
- in_ready  output  1  block accepts a code this cycle.
- y  output  8  registered one-hot decoded output.
- y_valid  output  1  y is being driven for an accepted code.
- y_last  output  1  final cycle of the current drive window.
- busy  output  1  block is not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-004 in_ready SHALL equal (state==IDLE) and en and not rst, combinationally.
REQ-005 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; i and in_none are sampled only then.
REQ-006 On acceptance, next state SHALL be DRIVE, hold counter loaded with HOLD-1.
REQ-007 In DRIVE with in_none=0 captured, y SHALL be 8'b1 shifted left by captured i (i=7 -> 8'b1000_0000, i=0 -> 8'b0000_0001).
REQ-008 In DRIVE with in_none=1 captured, y SHALL be 8'h00 while y_valid is still 1.
REQ-009 Latency: y/y_valid SHALL be asserted on the first cycle after the acceptance edge, for exactly HOLD consecutive cycles.
REQ-010 Hold counter SHALL decrement by 1 each DRIVE cycle; y_last SHALL be 1 exactly when state==DRIVE and counter==0.
REQ-011 From DRIVE with counter==0, next state SHALL be GAP; GAP SHALL last exactly 1 cycle with y=8'h00, y_valid=0, then return to IDLE.
REQ-012 Codes presented outside IDLE SHALL be ignored (not queued); the source holds in_valid until in_ready.
REQ-013 Minimum spacing between accepted codes SHALL be HOLD+2 cycles (HOLD drive + 1 gap + 1 idle accept).
REQ-014 If en=0 in DRIVE or GAP, next state SHALL be IDLE with y=8'h00, y_valid=0, y_last=0 on the following cycle (abort; no GAP).
REQ-015 HOLD=1 SHALL yield a single DRIVE cycle with y_valid and y_last both 1.
REQ-016 busy SHALL be 1 in DRIVE and GAP, 0 in IDLE.
REQ-017 y SHALL never have more than one bit set in any cycle.
REQ-018 X on i or in_none while not accepting SHALL NOT affect any output.

Reset
REQ-019 When rst=1 at a rising edge, state SHALL become IDLE, counter 0, y=8'h00, y_valid=0, y_last=0, busy=0, regardless of current state.
REQ-020 rst SHALL take priority over acceptance and en in the same cycle; in_ready SHALL be 0 while rst=1.
REQ-021 Reset mid-DRIVE SHALL discard the captured code; no GAP cycle follows.

Verification
REQ-022 HOLD=4, en=1, accept i=3'b111 -> y=8'h80, y_valid=1 for 4 cycles, y_last on 4th, then 1 cycle y=8'h00 busy=1, then in_ready=1.
REQ-023 Sweep i=7..0 back-to-back with in_valid held -> y=8'h80,40,20,10,08,04,02,01 in order, each accepted exactly HOLD+2 cycles apart.
REQ-024 Accept in_none=1, i=3'b000 -> y=8'h00 with y_valid=1 for HOLD cycles; then accept i=3'b000, in_none=0 -> y=8'h01.
REQ-025 Drop en to 0 on 2nd DRIVE cycle of i=3'b101 -> next cycle y=8'h00, y_valid=0, busy=0; in_ready stays 0 until en=1.
REQ-026 Assert rst on 3rd DRIVE cycle -> next cycle all outputs 0, state IDLE; with rst=1 and in_valid=1, no acceptance occurs.
REQ-027 HOLD=1, i=3'b010 -> one cycle y=8'h04 with y_valid=1 and y_last=1, one GAP cycle, then in_ready=1.
